// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage.
// Takes the registered EX/MEM fields, runs loads and stores one byte per cycle over the 8-bit
// RAM port and hands write-back fields to the MEM/WB register. While a transfer is in flight,
// stallreq holds the front of the pipeline.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   mem_wd/mem_wreg/mem_wdata destination, write enable, ALU result from EX/MEM
//   mem_aluop/mem_sub_aluop   operation class, funct3 in sub-op bits [2:0]
//   mem_mem_address/mem_reg2  effective address, store data
//   hold                      downstream stall, the result must be held
//   ram_busy                  RAM port owned by fetch, no new transfer may start
//   ram_din                   read byte, valid one cycle after its address
//   ram_addr/ram_dout/ram_we  byte-serial RAM port
//   wb_wd/wb_wreg/wb_wdata    write-back fields
//   stallreq                  stall request for the earlier stages
module mem_access_stage #(
    parameter int unsigned     OP_W     = 8,
    parameter int unsigned     SUBOP_W  = 8,
    parameter logic [OP_W-1:0] OP_LOAD  = OP_W'(8'h01),
    parameter logic [OP_W-1:0] OP_STORE = OP_W'(8'h02),
    parameter int unsigned     RAM_AW   = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         mem_wd,
    input  logic               mem_wreg,
    input  logic [31:0]        mem_wdata,
    input  logic [OP_W-1:0]    mem_aluop,
    input  logic [SUBOP_W-1:0] mem_sub_aluop,
    input  logic [31:0]        mem_mem_address,
    input  logic [31:0]        mem_reg2,
    input  logic               hold,
    input  logic               ram_busy,
    input  logic [7:0]         ram_din,
    output logic [RAM_AW-1:0]  ram_addr,
    output logic [7:0]         ram_dout,
    output logic               ram_we,
    output logic [4:0]         wb_wd,
    output logic               wb_wreg,
    output logic [31:0]        wb_wdata,
    output logic               stallreq
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;

    logic              is_load, is_store, is_mem, zext;
    logic [1:0]        last_idx;
    logic [1:0]        cnt_m1;
    logic [RAM_AW-1:0] base_addr;
    logic [31:0]       load_ext;
    logic              unused_hi;

    assign is_load   = (mem_aluop == OP_LOAD);
    assign is_store  = (mem_aluop == OP_STORE);
    assign is_mem    = is_load | is_store;
    assign zext      = mem_sub_aluop[2];
    assign base_addr = mem_mem_address[RAM_AW-1:0];
    assign cnt_m1    = cnt_q - 2'd1;
    assign unused_hi = ^{mem_mem_address[31:RAM_AW], mem_sub_aluop[SUBOP_W-1:3]};

    // Index of the last byte: 1, 2 or 4 byte transfers; funct3 size 11 is treated as a word.
    always_comb begin
        case (mem_sub_aluop[1:0])
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    always_comb begin
        case (mem_sub_aluop[1:0])
            2'b00:   load_ext = {{24{~zext & buf_q[7]}}, buf_q[7:0]};
            2'b01:   load_ext = {{16{~zext & buf_q[15]}}, buf_q[15:0]};
            default: load_ext = buf_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        ram_addr = '0;
        ram_dout = '0;
        ram_we   = 1'b0;
        wb_wd    = '0;
        wb_wreg  = 1'b0;
        wb_wdata = '0;
        stallreq = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!is_mem) begin
                    wb_wd    = mem_wd;
                    wb_wreg  = mem_wreg;
                    wb_wdata = mem_wdata;
                end else begin
                    stallreq = 1'b1;
                    // ram_busy only gates the start; afterwards the transfer owns the port.
                    if (!ram_busy) begin
                        ram_addr = base_addr;
                        ram_we   = is_store;
                        ram_dout = is_store ? mem_reg2[7:0] : 8'h00;
                        cnt_d    = 2'd1;
                        if (last_idx != 2'd0) begin
                            state_d = StAccess;
                        end else begin
                            state_d = is_store ? StDone : StWait;
                        end
                    end
                end
            end
            StAccess: begin
                stallreq = 1'b1;
                ram_addr = base_addr + RAM_AW'(cnt_q);
                if (is_store) begin
                    ram_we   = 1'b1;
                    ram_dout = mem_reg2[{cnt_q, 3'b000} +: 8];
                end else begin
                    // Read data lags its address by one cycle.
                    buf_d[{cnt_m1, 3'b000} +: 8] = ram_din;
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == last_idx) begin
                    state_d = is_store ? StDone : StWait;
                end
            end
            StWait: begin
                stallreq = 1'b1;
                buf_d[{last_idx, 3'b000} +: 8] = ram_din;
                state_d = StDone;
            end
            StDone: begin
                wb_wd    = mem_wd;
                wb_wreg  = mem_wreg;
                wb_wdata = is_load ? load_ext : mem_wdata;
                if (!hold) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
        endcase

        // Reset silences every output immediately, even mid-transfer.
        if (!rst) begin
            ram_addr = '0;
            ram_dout = '0;
            ram_we   = 1'b0;
            wb_wd    = '0;
            wb_wreg  = 1'b0;
            wb_wdata = '0;
            stallreq = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a byte RAM environment, a reference memory model, directed cases
// and random transactions. Expected write-back results and RAM writes go into queues; monitors
// compare them when the stage presents them.
module tb_mem_access_stage;

    localparam logic [7:0]  OP_LOAD  = 8'h01;
    localparam logic [7:0]  OP_STORE = 8'h02;
    localparam int          MEM_SIZE = 1 << 17;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [7:0]  mem_sub_aluop;
    logic [31:0] mem_mem_address;
    logic [31:0] mem_reg2;
    logic        hold;
    logic        ram_busy;
    logic [7:0]  ram_din;
    logic [16:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        int          stall;
    } wb_exp_t;

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
    } wr_exp_t;

    wb_exp_t    exp_q[$];
    wr_exp_t    wr_q[$];
    logic [7:0] ram_m [MEM_SIZE];
    logic [7:0] ref_m [MEM_SIZE];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         stall_cnt = 0;

    mem_access_stage #(
        .OP_W     (8),
        .SUBOP_W  (8),
        .OP_LOAD  (OP_LOAD),
        .OP_STORE (OP_STORE),
        .RAM_AW   (17)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_wd          (mem_wd),
        .mem_wreg        (mem_wreg),
        .mem_wdata       (mem_wdata),
        .mem_aluop       (mem_aluop),
        .mem_sub_aluop   (mem_sub_aluop),
        .mem_mem_address (mem_mem_address),
        .mem_reg2        (mem_reg2),
        .hold            (hold),
        .ram_busy        (ram_busy),
        .ram_din         (ram_din),
        .ram_addr        (ram_addr),
        .ram_dout        (ram_dout),
        .ram_we          (ram_we),
        .wb_wd           (wb_wd),
        .wb_wreg         (wb_wreg),
        .wb_wdata        (wb_wdata),
        .stallreq        (stallreq)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: read data appears one cycle after the address.
    always @(posedge clk) begin
        if (ram_we) ram_m[ram_addr] <= ram_dout;
        ram_din <= ram_m[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
        end
    endtask

    // Write-back monitor.
    always @(negedge clk) begin
        if (!rst) begin
            stall_cnt = 0;
        end else if (stallreq) begin
            stall_cnt++;
            check("wreg_low_while_stalled", {31'd0, wb_wreg}, 32'd0);
        end else if (exp_q.size() == 0) begin
            check("idle_wreg", {31'd0, wb_wreg}, 32'd0);
        end else begin
            check("wb_wd", {27'd0, wb_wd}, {27'd0, exp_q[0].wd});
            check("wb_wreg", {31'd0, wb_wreg}, {31'd0, exp_q[0].wreg});
            check("wb_wdata", wb_wdata, exp_q[0].wdata);
            if (!hold) begin
                check("stall_cycles", 32'(stall_cnt), 32'(exp_q[0].stall));
                void'(exp_q.pop_front());
                stall_cnt = 0;
            end
        end
    end

    // RAM write monitor.
    always @(negedge clk) begin
        if (ram_we) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_write: got addr 0x%05h data 0x%02h, expected no write",
                         ram_addr, ram_dout);
            end else begin
                check("wr_addr", {15'd0, ram_addr}, {15'd0, wr_q[0].addr});
                check("wr_data", {24'd0, ram_dout}, {24'd0, wr_q[0].data});
                void'(wr_q.pop_front());
            end
        end
    end

    task automatic set_nop();
        mem_aluop = 8'h00; mem_sub_aluop = 8'h00; mem_wd = '0; mem_wreg = 1'b0;
        mem_wdata = '0; mem_mem_address = '0; mem_reg2 = '0; hold = 1'b0; ram_busy = 1'b0;
    endtask

    // Issue one instruction, predict its results, then steer busy/hold until it retires.
    task automatic issue(input logic [7:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] wdata, input logic [4:0] wd,
                         input logic wreg, input int b, input int h);
        int          n;
        logic [31:0] v;
        logic [16:0] ad;
        logic [4:0]  junk;
        wb_exp_t     e;
        wr_exp_t     w;
        bit          done;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.stall = 0;
        if (op == OP_LOAD) begin
            v = 0;
            for (int k = 0; k < n; k++) begin
                ad = 17'(a + 32'(k));
                v = v | (32'(ref_m[ad]) << (8 * k));
            end
            if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
            e.wdata = v;
            e.stall = b + n + 1;
        end else if (op == OP_STORE) begin
            for (int k = 0; k < n; k++) begin
                w.addr = 17'(a + 32'(k));
                w.data = d[8*k +: 8];
                wr_q.push_back(w);
                ref_m[w.addr] = w.data;
            end
            e.stall = b + n;
        end else begin
            b = 0;
        end
        @(posedge clk);
        #1;
        junk = 5'($urandom);
        mem_aluop = op; mem_sub_aluop = {junk, f3}; mem_mem_address = a; mem_reg2 = d;
        mem_wdata = wdata; mem_wd = wd; mem_wreg = wreg;
        hold = (h > 0); ram_busy = (b > 0);
        exp_q.push_back(e);
        if (b > 0) begin
            repeat (b) @(posedge clk);
            #1 ram_busy = 1'b0;
        end
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!stallreq) begin
                done = 1;
            end else begin
                @(posedge clk);
                #1 ram_busy = 1'($urandom_range(0, 1));
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: stallreq still 1 after 40 cycles, expected 0");
        end
        if (h > 0) begin
            repeat (h) @(posedge clk);
            #1 hold = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] byte_v;
        for (int i = 0; i < MEM_SIZE; i++) begin
            byte_v = 8'($urandom);
            ram_m[i] = byte_v;
            ref_m[i] = byte_v;
        end

        // Reset state: outputs stay zero whatever the inputs.
        set_nop();
        mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'hDEAD;
        #3;
        check("rst_wb_wreg", {31'd0, wb_wreg}, 32'd0);
        check("rst_wb_wdata", wb_wdata, 32'd0);
        check("rst_wb_wd", {27'd0, wb_wd}, 32'd0);
        mem_aluop = OP_STORE; mem_reg2 = 32'h1234_5678;
        #1;
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_stallreq", {31'd0, stallreq}, 32'd0);
        check("rst_ram_addr", {15'd0, ram_addr}, 32'd0);
        set_nop();
        #10 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Word store then load of the same location.
        issue(OP_STORE, 3'b010, 32'h100, 32'h8899_AABB, 32'hCAFE_0000, 5'd0, 1'b0, 0, 0);
        issue(OP_LOAD, 3'b010, 32'h100, 32'h0, 32'h0, 5'd7, 1'b1, 0, 0);
        // Byte and half-word extension.
        issue(OP_STORE, 3'b000, 32'h300, 32'h0000_00F0, 32'h0, 5'd0, 1'b0, 0, 0);
        issue(OP_LOAD, 3'b000, 32'h300, 32'h0, 32'h0, 5'd8, 1'b1, 0, 0);
        issue(OP_LOAD, 3'b100, 32'h300, 32'h0, 32'h0, 5'd9, 1'b1, 0, 0);
        issue(OP_STORE, 3'b001, 32'h310, 32'h0000_8001, 32'h0, 5'd0, 1'b0, 0, 0);
        issue(OP_LOAD, 3'b001, 32'h310, 32'h0, 32'h0, 5'd10, 1'b1, 0, 0);
        issue(OP_LOAD, 3'b101, 32'h310, 32'h0, 32'h0, 5'd11, 1'b1, 0, 0);
        // Non-memory passthrough.
        issue(8'h00, 3'b000, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 0, 0);
        // Busy before start, then hold in DONE.
        issue(OP_STORE, 3'b000, 32'h320, 32'h0000_005A, 32'h77, 5'd3, 1'b1, 3, 2);
        // Address wrap at the top of RAM.
        issue(OP_STORE, 3'b001, 32'h1FFFF, 32'h0000_BEEF, 32'h0, 5'd0, 1'b0, 0, 0);
        issue(OP_LOAD, 3'b101, 32'h1FFFF, 32'h0, 32'h0, 5'd12, 1'b1, 0, 1);

        // Reset during a word store after two bytes have gone out.
        @(posedge clk);
        #1;
        mem_aluop = OP_STORE; mem_sub_aluop = 8'h02; mem_mem_address = 32'h200;
        mem_reg2 = 32'h1122_3344; mem_wdata = '0; mem_wd = '0; mem_wreg = 1'b0;
        hold = 1'b0; ram_busy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr_exp_t w;
            w.addr = 17'(32'h200 + 32'(k));
            w.data = mem_reg2[8*k +: 8];
            wr_q.push_back(w);
            ref_m[w.addr] = w.data;
        end
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_ram_we", {31'd0, ram_we}, 32'd0);
        check("abort_stallreq", {31'd0, stallreq}, 32'd0);
        set_nop();
        #10 rst = 1'b1;
        repeat (4) @(posedge clk);
        issue(OP_LOAD, 3'b010, 32'h200, 32'h0, 32'h0, 5'd13, 1'b1, 0, 0);

        // Random traffic clustered around the wrap point.
        for (int t = 0; t < 250; t++) begin
            int          sel;
            logic [7:0]  op;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            op = (sel < 4) ? OP_LOAD : (sel < 8) ? OP_STORE : ((sel == 8) ? 8'h00 : 8'h05);
            a = ($urandom & 32'hFFFE_0000) + 32'h1FFF0 + $urandom_range(0, 31);
            issue(op, 3'($urandom), a, $urandom, $urandom, 5'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, $urandom_range(0, 2));
        end

        @(posedge clk);
        #1 set_nop();
        repeat (3) @(posedge clk);
        check("wb_queue_drained", 32'(exp_q.size()), 32'd0);
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
